// File: rtl/lfdb_port_sched_if.sv
// Linefill data-buffer port bundle: write beat stream, line-read requests, SRAM control,
// read-beat sideband, entry allocation and completion pulses.
interface lfdb_port_sched_if #(
   parameter int unsigned ENTRY_NUM = 8
);
   localparam int unsigned EW = $clog2(ENTRY_NUM);

   logic          wr_vld;
   logic [EW-1:0] wr_entry;
   logic          wr_last;
   logic          wr_rdy;

   logic          rd_req_vld;
   logic [EW-1:0] rd_req_entry;
   logic          rd_req_rdy;

   logic          mem_en;
   logic          mem_wr_en;
   logic [EW+1:0] mem_addr;

   logic          rd_beat_vld;
   logic [EW-1:0] rd_beat_entry;
   logic [1:0]    rd_beat_num;
   logic          rd_beat_last;

   logic          alloc_vld;
   logic [EW-1:0] alloc_idx;
   logic          alloc_rdy;

   logic          fill_done;
   logic [EW-1:0] fill_done_entry;
   logic          drain_done;
   logic [EW-1:0] drain_done_entry;
   logic          err;

   modport master (
      output wr_vld, wr_entry, wr_last, rd_req_vld, rd_req_entry, alloc_rdy,
      input  wr_rdy, rd_req_rdy, mem_en, mem_wr_en, mem_addr, rd_beat_vld, rd_beat_entry,
             rd_beat_num, rd_beat_last, alloc_vld, alloc_idx, fill_done, fill_done_entry,
             drain_done, drain_done_entry, err
   );

   modport slave (
      input  wr_vld, wr_entry, wr_last, rd_req_vld, rd_req_entry, alloc_rdy,
      output wr_rdy, rd_req_rdy, mem_en, mem_wr_en, mem_addr, rd_beat_vld, rd_beat_entry,
             rd_beat_num, rd_beat_last, alloc_vld, alloc_idx, fill_done, fill_done_entry,
             drain_done, drain_done_entry, err
   );
endinterface

// File: rtl/lfdb_port_sched.sv
// Single-port SRAM scheduler for a linefill data buffer: per-entry FREE/ALLOC/FILLED tracking,
// beat-wise fill writes, 4-beat line drains with read priority and a write starvation guard.
module lfdb_port_sched #(
   parameter int unsigned ENTRY_NUM = 8,
   parameter int unsigned BEATS     = 4
) (
   input logic               clk,
   input logic               rst,
   lfdb_port_sched_if.slave  sched_if
);
   localparam int unsigned EW = $clog2(ENTRY_NUM);
   localparam int unsigned BW = $clog2(BEATS);
   localparam logic [BW-1:0] LastBeat = BW'(BEATS - 1);

   typedef enum logic [1:0] {EntFree = 2'd0, EntAlloc = 2'd1, EntFilled = 2'd2} ent_e;
   typedef enum logic {StIdle, StBurst} st_e;

   ent_e          r_ent [ENTRY_NUM];
   st_e           r_st;
   logic [BW-1:0] r_bcnt;
   logic [BW-1:0] r_wcnt;
   logic [EW-1:0] r_rd_entry;
   logic          r_held;
   logic [1:0]    r_starve;
   logic          r_err;
   logic          r_beat_vld;
   logic [EW-1:0] r_beat_entry;
   logic [BW-1:0] r_beat_num;

   logic          w_grant;
   logic          w_rd_req_rdy;
   logic          w_rd_hs;
   logic          w_wr_rdy;
   logic          w_wr_hs;
   logic          w_wr_ok;
   logic          w_wr_fill;
   logic          w_burst_beat;
   logic          w_rd_issue;
   logic          w_any_free;
   logic [EW-1:0] w_alloc_idx;
   logic          w_alloc_hs;
   logic          w_beat_vld;

   always_comb begin
      w_any_free  = 1'b0;
      w_alloc_idx = '0;
      for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
         if (r_ent[i] == EntFree) begin
            w_any_free  = 1'b1;
            w_alloc_idx = EW'(i);
         end
      end
   end

   // Two starved bursts in a row force the next idle cycle to the write stream.
   assign w_grant      = (r_st == StIdle) && (r_starve == 2'd2);
   assign w_rd_req_rdy = !rst && (r_st == StIdle) && !w_grant &&
                         (r_ent[sched_if.rd_req_entry] == EntFilled);
   assign w_rd_hs      = sched_if.rd_req_vld && w_rd_req_rdy;
   assign w_wr_rdy     = !rst && (r_st == StIdle) && !w_rd_hs;
   assign w_wr_hs      = sched_if.wr_vld && w_wr_rdy;
   assign w_wr_ok      = w_wr_hs && (r_ent[sched_if.wr_entry] == EntAlloc);
   assign w_wr_fill    = w_wr_ok && sched_if.wr_last && (r_wcnt == LastBeat);
   assign w_burst_beat = !rst && (r_st == StBurst);
   assign w_rd_issue   = w_rd_hs || w_burst_beat;
   assign w_alloc_hs   = !rst && w_any_free && sched_if.alloc_rdy;
   assign w_beat_vld   = !rst && r_beat_vld;

   always_comb begin
      if (w_rd_hs) begin
         sched_if.mem_addr = {sched_if.rd_req_entry, BW'(0)};
      end else if (w_burst_beat) begin
         sched_if.mem_addr = {r_rd_entry, r_bcnt};
      end else begin
         sched_if.mem_addr = {sched_if.wr_entry, r_wcnt};
      end
   end

   assign sched_if.mem_en           = w_rd_issue || w_wr_ok;
   assign sched_if.mem_wr_en        = w_wr_ok;
   assign sched_if.wr_rdy           = w_wr_rdy;
   assign sched_if.rd_req_rdy       = w_rd_req_rdy;
   assign sched_if.alloc_vld        = !rst && w_any_free;
   assign sched_if.alloc_idx        = w_alloc_idx;
   assign sched_if.rd_beat_vld      = w_beat_vld;
   assign sched_if.rd_beat_entry    = r_beat_entry;
   assign sched_if.rd_beat_num      = r_beat_num;
   assign sched_if.rd_beat_last     = (r_beat_num == LastBeat);
   assign sched_if.drain_done       = w_beat_vld && (r_beat_num == LastBeat);
   assign sched_if.drain_done_entry = r_beat_entry;
   assign sched_if.fill_done        = w_wr_fill;
   assign sched_if.fill_done_entry  = sched_if.wr_entry;
   assign sched_if.err              = r_err;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < ENTRY_NUM; i++) begin
            r_ent[i] <= EntFree;
         end
         r_st         <= StIdle;
         r_bcnt       <= '0;
         r_wcnt       <= '0;
         r_rd_entry   <= '0;
         r_held       <= 1'b0;
         r_starve     <= '0;
         r_err        <= 1'b0;
         r_beat_vld   <= 1'b0;
         r_beat_entry <= '0;
         r_beat_num   <= '0;
      end else begin
         if (w_alloc_hs) begin
            r_ent[w_alloc_idx] <= EntAlloc;
         end

         if (w_wr_hs) begin
            if (w_wr_ok) begin
               if (sched_if.wr_last) begin
                  r_wcnt <= '0;
                  if (r_wcnt == LastBeat) begin
                     r_ent[sched_if.wr_entry] <= EntFilled;
                  end else begin
                     r_err <= 1'b1;
                  end
               end else begin
                  r_wcnt <= r_wcnt + 1'b1;
               end
            end else begin
               r_err <= 1'b1;
            end
         end

         r_beat_vld   <= w_rd_issue;
         r_beat_entry <= w_rd_hs ? sched_if.rd_req_entry : r_rd_entry;
         r_beat_num   <= w_rd_hs ? '0 : r_bcnt;

         if (w_wr_hs || w_grant) begin
            r_starve <= '0;
         end

         unique case (r_st)
            StIdle: begin
               if (w_rd_hs) begin
                  r_st       <= StBurst;
                  r_bcnt     <= BW'(1);
                  r_rd_entry <= sched_if.rd_req_entry;
                  r_held     <= sched_if.wr_vld;
               end
            end
            StBurst: begin
               r_bcnt <= r_bcnt + 1'b1;
               r_held <= r_held && sched_if.wr_vld;
               if (r_bcnt == LastBeat) begin
                  r_st              <= StIdle;
                  r_ent[r_rd_entry] <= EntFree;
                  if (r_held && sched_if.wr_vld && (r_starve != 2'd2)) begin
                     r_starve <= r_starve + 2'd1;
                  end
               end
            end
            default: r_st <= StIdle;
         endcase
      end
   end
endmodule

// File: tb/tb_lfdb_port_sched.sv
// Directed bench for lfdb_port_sched: allocation order, fill, drain timing, read priority,
// starvation grant, protocol errors and mid-burst reset.
module tb_lfdb_port_sched;
   logic clk;
   logic rst;
   int   total;
   int   bad;

   lfdb_port_sched_if #(.ENTRY_NUM(8)) bus ();

   lfdb_port_sched #(
      .ENTRY_NUM(8),
      .BEATS    (4)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .sched_if(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      bus.wr_vld       = 1'b0;
      bus.wr_entry     = '0;
      bus.wr_last      = 1'b0;
      bus.rd_req_vld   = 1'b0;
      bus.rd_req_entry = '0;
      bus.alloc_rdy    = 1'b0;

      // Reset state
      cyc();
      cyc();
      #2;
      chk("rst_alloc_vld", 32'(bus.alloc_vld), 0);
      chk("rst_wr_rdy", 32'(bus.wr_rdy), 0);
      chk("rst_mem_en", 32'(bus.mem_en), 0);
      chk("rst_rd_req_rdy", 32'(bus.rd_req_rdy), 0);
      chk("rst_err", 32'(bus.err), 0);
      cyc();
      rst = 1'b0;
      #2;
      chk("alloc_vld", 32'(bus.alloc_vld), 1);

      // Allocation order 0,1,2 then 3; one more so entry 3 is ALLOC
      bus.alloc_rdy = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #2;
         chk("alloc_idx", 32'(bus.alloc_idx), 32'(k));
         cyc();
      end
      bus.alloc_rdy = 1'b0;
      #2;
      chk("alloc_idx3", 32'(bus.alloc_idx), 3);
      bus.alloc_rdy = 1'b1;
      cyc();
      bus.alloc_rdy = 1'b0;
      #2;
      chk("alloc_idx4", 32'(bus.alloc_idx), 4);

      // Fill entry 2
      for (int k = 0; k < 4; k++) begin
         bus.wr_vld   = 1'b1;
         bus.wr_entry = 3'd2;
         bus.wr_last  = (k == 3);
         #2;
         chk("fill2_wr_rdy", 32'(bus.wr_rdy), 1);
         chk("fill2_mem_en", 32'(bus.mem_en), 1);
         chk("fill2_wr_en", 32'(bus.mem_wr_en), 1);
         chk("fill2_addr", 32'(bus.mem_addr), 32'(8 + k));
         chk("fill2_done", 32'(bus.fill_done), (k == 3) ? 1 : 0);
         if (k == 3) chk("fill2_done_entry", 32'(bus.fill_done_entry), 2);
         cyc();
      end
      bus.wr_vld  = 1'b0;
      bus.wr_last = 1'b0;

      // Drain entry 2
      bus.rd_req_vld   = 1'b1;
      bus.rd_req_entry = 3'd2;
      #2;
      chk("rd_t0_rdy", 32'(bus.rd_req_rdy), 1);
      chk("rd_t0_mem_en", 32'(bus.mem_en), 1);
      chk("rd_t0_wr_en", 32'(bus.mem_wr_en), 0);
      chk("rd_t0_addr", 32'(bus.mem_addr), 8);
      chk("rd_t0_wr_rdy", 32'(bus.wr_rdy), 0);
      chk("rd_t0_beat_vld", 32'(bus.rd_beat_vld), 0);
      cyc();
      bus.rd_req_vld = 1'b0;
      for (int k = 1; k < 4; k++) begin
         #2;
         chk("rd_burst_mem_en", 32'(bus.mem_en), 1);
         chk("rd_burst_wr_en", 32'(bus.mem_wr_en), 0);
         chk("rd_burst_addr", 32'(bus.mem_addr), 32'(8 + k));
         chk("rd_burst_beat_vld", 32'(bus.rd_beat_vld), 1);
         chk("rd_burst_beat_num", 32'(bus.rd_beat_num), 32'(k - 1));
         chk("rd_burst_beat_last", 32'(bus.rd_beat_last), 0);
         chk("rd_burst_wr_rdy", 32'(bus.wr_rdy), 0);
         chk("rd_burst_alloc_idx", 32'(bus.alloc_idx), 4);
         cyc();
      end
      #2;
      chk("rd_t4_mem_en", 32'(bus.mem_en), 0);
      chk("rd_t4_beat_vld", 32'(bus.rd_beat_vld), 1);
      chk("rd_t4_beat_num", 32'(bus.rd_beat_num), 3);
      chk("rd_t4_beat_last", 32'(bus.rd_beat_last), 1);
      chk("rd_t4_drain", 32'(bus.drain_done), 1);
      chk("rd_t4_drain_entry", 32'(bus.drain_done_entry), 2);
      chk("rd_t4_alloc_idx", 32'(bus.alloc_idx), 2);
      chk("rd_t4_wr_rdy", 32'(bus.wr_rdy), 1);
      cyc();

      // Fill entry 0
      for (int k = 0; k < 4; k++) begin
         bus.wr_vld   = 1'b1;
         bus.wr_entry = 3'd0;
         bus.wr_last  = (k == 3);
         #2;
         chk("fill0_addr", 32'(bus.mem_addr), 32'(k));
         chk("fill0_done", 32'(bus.fill_done), (k == 3) ? 1 : 0);
         cyc();
      end
      bus.wr_vld  = 1'b0;
      bus.wr_last = 1'b0;

      // Read of an unfilled entry waits for its fill
      bus.rd_req_vld   = 1'b1;
      bus.rd_req_entry = 3'd1;
      #2;
      chk("unfilled_rdy", 32'(bus.rd_req_rdy), 0);
      for (int k = 0; k < 4; k++) begin
         bus.wr_vld   = 1'b1;
         bus.wr_entry = 3'd1;
         bus.wr_last  = (k == 3);
         #2;
         chk("fill1_rd_rdy", 32'(bus.rd_req_rdy), 0);
         chk("fill1_wr_rdy", 32'(bus.wr_rdy), 1);
         chk("fill1_addr", 32'(bus.mem_addr), 32'(4 + k));
         chk("fill1_done", 32'(bus.fill_done), (k == 3) ? 1 : 0);
         cyc();
      end

      // Back-to-back reads with a write held pending to entry 3
      bus.wr_vld   = 1'b1;
      bus.wr_entry = 3'd3;
      bus.wr_last  = 1'b0;
      #2;
      chk("b1_t0_rd_rdy", 32'(bus.rd_req_rdy), 1);
      chk("b1_t0_wr_rdy", 32'(bus.wr_rdy), 0);
      chk("b1_t0_addr", 32'(bus.mem_addr), 4);
      chk("b1_t0_wr_en", 32'(bus.mem_wr_en), 0);
      cyc();
      bus.rd_req_entry = 3'd0;
      for (int k = 1; k < 4; k++) begin
         #2;
         chk("b1_rd_rdy", 32'(bus.rd_req_rdy), 0);
         chk("b1_wr_rdy", 32'(bus.wr_rdy), 0);
         chk("b1_addr", 32'(bus.mem_addr), 32'(4 + k));
         cyc();
      end
      #2;
      chk("b2_t0_rd_rdy", 32'(bus.rd_req_rdy), 1);
      chk("b2_t0_wr_rdy", 32'(bus.wr_rdy), 0);
      chk("b2_t0_addr", 32'(bus.mem_addr), 0);
      chk("b1_drain", 32'(bus.drain_done), 1);
      chk("b1_drain_entry", 32'(bus.drain_done_entry), 1);
      cyc();
      bus.rd_req_vld = 1'b0;
      for (int k = 1; k < 4; k++) begin
         #2;
         chk("b2_wr_rdy", 32'(bus.wr_rdy), 0);
         chk("b2_addr", 32'(bus.mem_addr), 32'(k));
         cyc();
      end
      #2;
      chk("grant_wr_rdy", 32'(bus.wr_rdy), 1);
      chk("grant_rd_rdy", 32'(bus.rd_req_rdy), 0);
      chk("grant_wr_en", 32'(bus.mem_wr_en), 1);
      chk("grant_addr", 32'(bus.mem_addr), 12);
      chk("b2_drain_entry", 32'(bus.drain_done_entry), 0);
      cyc();

      // Finish filling entry 3
      for (int k = 1; k < 4; k++) begin
         bus.wr_last = (k == 3);
         #2;
         chk("fill3_addr", 32'(bus.mem_addr), 32'(12 + k));
         chk("fill3_done", 32'(bus.fill_done), (k == 3) ? 1 : 0);
         cyc();
      end

      // Write to a FREE entry
      bus.wr_entry = 3'd5;
      bus.wr_last  = 1'b0;
      #2;
      chk("free_wr_rdy", 32'(bus.wr_rdy), 1);
      chk("free_mem_en", 32'(bus.mem_en), 0);
      chk("free_err_before", 32'(bus.err), 0);
      cyc();
      bus.wr_vld = 1'b0;
      #2;
      chk("free_err", 32'(bus.err), 1);
      cyc();
      #2;
      chk("free_err_sticky", 32'(bus.err), 1);

      // Reset in the middle of a burst on entry 3
      bus.rd_req_vld   = 1'b1;
      bus.rd_req_entry = 3'd3;
      #2;
      chk("mid_rd_rdy", 32'(bus.rd_req_rdy), 1);
      cyc();
      bus.rd_req_vld = 1'b0;
      rst = 1'b1;
      #2;
      chk("mid_rst_beat_vld", 32'(bus.rd_beat_vld), 0);
      chk("mid_rst_drain", 32'(bus.drain_done), 0);
      chk("mid_rst_mem_en", 32'(bus.mem_en), 0);
      chk("mid_rst_alloc_vld", 32'(bus.alloc_vld), 0);
      cyc();
      rst = 1'b0;
      bus.rd_req_vld = 1'b1;
      #2;
      chk("post_rst_beat_vld", 32'(bus.rd_beat_vld), 0);
      chk("post_rst_mem_en", 32'(bus.mem_en), 0);
      chk("post_rst_err", 32'(bus.err), 0);
      chk("post_rst_alloc_idx", 32'(bus.alloc_idx), 0);
      chk("post_rst_rd_rdy", 32'(bus.rd_req_rdy), 0);
      bus.rd_req_vld = 1'b0;
      cyc();
      #2;
      chk("post_rst_beat_vld2", 32'(bus.rd_beat_vld), 0);
      chk("post_rst_drain2", 32'(bus.drain_done), 0);

      // wr_last on beat 2 of entry 0
      bus.alloc_rdy = 1'b1;
      #2;
      chk("short_alloc_idx", 32'(bus.alloc_idx), 0);
      cyc();
      bus.alloc_rdy = 1'b0;
      bus.wr_vld    = 1'b1;
      bus.wr_entry  = 3'd0;
      bus.wr_last   = 1'b0;
      #2;
      chk("short_b0_addr", 32'(bus.mem_addr), 0);
      cyc();
      bus.wr_last = 1'b1;
      #2;
      chk("short_b1_addr", 32'(bus.mem_addr), 1);
      chk("short_b1_mem_en", 32'(bus.mem_en), 1);
      chk("short_b1_fill", 32'(bus.fill_done), 0);
      chk("short_b1_err_before", 32'(bus.err), 0);
      cyc();
      bus.wr_last = 1'b0;
      #2;
      chk("short_err", 32'(bus.err), 1);
      chk("short_still_alloc_en", 32'(bus.mem_en), 1);
      chk("short_wcnt_clear", 32'(bus.mem_addr), 0);
      cyc();
      bus.wr_vld = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/lfdb_port_sched.md
LFDB_PORT_SCHED -- requirements
Module: lfdb_port_sched

Interface
REQ-001 SHALL have parameter ENTRY_NUM, default 8, meaning the number of line entries; it SHALL be a power of two and at least 2.
REQ-002 SHALL have parameter BEATS, default 4 (fixed), meaning the number of 1024-bit beats per line.
REQ-003 SHALL derive EW = $clog2(ENTRY_NUM).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have the write-stream ports: wr_vld (input, 1), wr_entry (input, EW), wr_last (input, 1) and wr_rdy (output, 1). This is the downstream linefill beat stream.
REQ-007 SHALL have the line-read request ports: rd_req_vld (input, 1), rd_req_entry (input, EW) and rd_req_rdy (output, 1).
REQ-008 SHALL have the SRAM control outputs mem_en (1), mem_wr_en (1) and mem_addr (EW+2); mem_addr = {entry, beat}.
REQ-009 SHALL have the read-beat outputs rd_beat_vld (1), rd_beat_entry (EW), rd_beat_num (2) and rd_beat_last (1); these align with SRAM rd_data.
REQ-010 SHALL have the allocation ports alloc_vld (output, 1), alloc_idx (output, EW) and alloc_rdy (input, 1).
REQ-011 SHALL have the completion pulses fill_done and fill_done_entry (EW), and drain_done and drain_done_entry (EW).
REQ-012 SHALL have output err (1): sticky protocol-error flag.

Function
REQ-013 SHALL hold a 2-bit state per entry: FREE, ALLOC or FILLED.
REQ-014 SHALL drive alloc_vld=1 whenever any entry is FREE, with alloc_idx = lowest-index FREE entry; on alloc_vld&&alloc_rdy that entry SHALL become ALLOC at the next edge.
REQ-015 SHALL use a port FSM with states IDLE and BURST, a 2-bit beat counter bcnt, and a 2-bit write counter wcnt.
REQ-016 SHALL drive rd_req_rdy=1 only in IDLE when entry[rd_req_entry]==FILLED and no starvation grant (REQ-021) is active.
REQ-017 On an rd_req handshake in cycle t0, the block SHALL:
- issue beat 0 that cycle (mem_en=1, mem_wr_en=0, mem_addr={rd_req_entry,0});
- go to BURST;
- issue beats 1..3 in cycles t0+1..t0+3;
- return to IDLE after beat 3.
A new handshake SHALL be possible at t0+4 at the earliest.
REQ-018 SHALL register the read-beat outputs 1 cycle after issue: rd_beat_vld is high in t0+1..t0+4, with rd_beat_num 0..3 and rd_beat_last=1 on beat 3. There is no output backpressure.
REQ-019 SHALL pulse drain_done with rd_beat_last; the entry SHALL become FREE at the edge ending t0+3, so it is allocatable in t0+4.
REQ-020 SHALL drive wr_rdy=0 in BURST and in any cycle with an rd_req handshake. Otherwise wr_rdy=1; reads have priority.
REQ-021 SHALL provide a starvation guard:
- a counter counts completed bursts during which wr_vld stayed high without a handshake;
- when it reaches 2, the next IDLE cycle SHALL grant the write (wr_rdy=1, rd_req_rdy=0) and clear the counter.
REQ-022 On a write handshake to an ALLOC entry, the block SHALL:
- drive mem_en=1, mem_wr_en=1, mem_addr={wr_entry,wcnt} that cycle;
- increment wcnt, wrapping 3->0.
REQ-023 When wr_last is set on a write handshake:
- if wcnt==3, fill_done SHALL pulse that cycle with fill_done_entry=wr_entry, the entry SHALL become FILLED at the next edge, and wcnt SHALL clear;
- if wcnt!=3, err SHALL set, wcnt SHALL clear, and the entry SHALL stay ALLOC.
REQ-024 A write handshake to a non-ALLOC entry SHALL set err, suppress mem_en, and leave wcnt unchanged.
REQ-025 SHALL drive mem_en=0 when there is no handshake and no burst beat.
REQ-026 SHALL never assert a read issue and a write issue in the same cycle.

Reset
REQ-027 While rst=1, the block SHALL hold all entries FREE, the FSM in IDLE, all counters at 0, and err=0.
REQ-028 While rst=1, the block SHALL drive alloc_vld, wr_rdy, rd_req_rdy, mem_en, rd_beat_vld, fill_done and drain_done to 0.
REQ-029 Reset asserted mid-burst SHALL abort the burst; no rd_beat_vld or drain_done SHALL follow the reset cycle.

Verification
REQ-030 After reset, pulse alloc_rdy 3 times -> alloc_idx 0,1,2 in order; then alloc_idx=3.
REQ-031 Allocate entry 2; write 4 beats with wr_last on beat 4 -> mem_addr 8,9,10,11 with mem_wr_en=1; fill_done with fill_done_entry=2 on beat 4.
REQ-032 rd_req for entry 2 one cycle after fill_done -> mem_addr 8..11 with mem_wr_en=0 in t0..t0+3; rd_beat_vld t0+1..t0+4 with rd_beat_num 0..3; drain_done at t0+4; alloc_idx=2 available at t0+4 if it is the lowest FREE entry.
REQ-033 Hold wr_vld high through back-to-back rd_reqs -> wr_rdy=0 during both bursts; the write is granted in the first IDLE cycle after the 2nd burst.
REQ-034 Error cases -> err=1 and stays 1 until reset:
- write to a FREE entry -> err=1, mem_en=0;
- wr_last on beat 2 -> err=1.
REQ-035 rd_req to an ALLOC (unfilled) entry -> rd_req_rdy=0 until that entry's fill_done, then accepted the next cycle.
